// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit 5-stage core: widths, special opcodes and fetch states.
package core_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PC_W    = 3;
  localparam int unsigned IMEM_W  = INSTR_W * DEPTH;

  localparam logic [INSTR_W-1:0] NOP_INSTR   = 8'h00;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/instr_slot_mux.sv
// Combinational selector: picks one INSTR_W-bit slot out of the instruction image.
module instr_slot_mux
  import core_pkg::*;
(
  input  logic [IMEM_W-1:0]  instrMem,
  input  logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr_c
);

  // Slot i lives at instrMem[INSTR_W*i +: INSTR_W]
  always_comb begin
    instr_c = NOP_INSTR;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (pc == PC_W'(i)) instr_c = instrMem[i*INSTR_W +: INSTR_W];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC sequencing over the loaded image, IF/ID register,
// stall hold and branch redirect. Optional halt opcode support under IF_HALT_EN.
module instr_fetch
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [IMEM_W-1:0]   instrMem,
  input  logic                mem_ready,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_target,
  output logic [PC_W-1:0]     pc,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [PC_W-1:0]     if_id_pc,
  output logic                if_id_valid,
  output logic                halted
);

  localparam if_id_t IF_ID_RST = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  if_id_t             if_id_q, if_id_d;
  logic               halted_q, halted_d;
  logic [INSTR_W-1:0] slot_instr_c;

  instr_slot_mux u_slot_mux (
    .instrMem (instrMem),
    .pc       (pc_q),
    .instr_c  (slot_instr_c)
  );

  // Next-state, PC and IF/ID update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    if_id_d  = if_id_q;
    halted_d = halted_q;

    unique case (state_q)
      IDLE: begin
        pc_d     = '0;
        if_id_d  = IF_ID_RST;
        halted_d = 1'b0;
        if (mem_ready) state_d = RUN;
      end

      RUN: begin
        if (!mem_ready) begin
          state_d  = IDLE;
          pc_d     = '0;
          if_id_d  = IF_ID_RST;
          halted_d = 1'b0;
        end else if (branch_taken) begin
          pc_d           = branch_target;
          if_id_d.instr  = NOP_INSTR;
          if_id_d.valid  = 1'b0;
        end else if (!stall) begin
          if_id_d.instr = slot_instr_c;
          if_id_d.pc    = pc_q;
          if_id_d.valid = 1'b1;
          pc_d          = pc_q + PC_W'(1);
`ifdef IF_HALT_EN
          if (slot_instr_c == HALT_OPCODE) begin
            state_d  = HALT;
            halted_d = 1'b1;
            pc_d     = pc_q;
          end
`endif
        end
      end

      HALT: begin
        if (!mem_ready) begin
          state_d  = IDLE;
          pc_d     = '0;
          if_id_d  = IF_ID_RST;
          halted_d = 1'b0;
        end else begin
          // Bubbles until an older in-flight branch redirects us
          if_id_d.instr = NOP_INSTR;
          if_id_d.valid = 1'b0;
          if (branch_taken) begin
            state_d  = RUN;
            pc_d     = branch_target;
            halted_d = 1'b0;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        pc_d     = '0;
        if_id_d  = IF_ID_RST;
        halted_d = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      if_id_q  <= IF_ID_RST;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      halted_q <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_valid = if_id_q.valid;
  assign halted      = halted_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the 8-bit 5-stage core. Consumes the 64-bit, eight-slot instruction image assembled by the input-mode loader. Sequences a program counter over that image and drives the IF/ID pipeline register. Honours hazard-unit stalls and EX-stage branch redirects.

## Interface
- INSTR_W, 8, instruction width in bits
- DEPTH, 8, number of instruction slots
- PC_W, 3, program counter width (log2 DEPTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instrMem  in  64  instruction image; slot i = instrMem[8*i+7 : 8*i], slot 0 executes first
- mem_ready  in  1  loader has finished; image is stable
- stall  in  1  hazard-unit stall request
- branch_taken  in  1  EX-stage redirect request
- branch_target  in  3  redirect slot index
- pc  out  3  current fetch slot
- if_id_instr  out  8  IF/ID instruction
- if_id_pc  out  3  slot index of if_id_instr
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  halt opcode fetched; fetch frozen

## Operation
- States:
  - IDLE: waiting for the image.
  - RUN: fetching.
  - HALT: halt opcode has been fetched.
- Reset (rst=1 at an edge): state=IDLE, pc=0, if_id_instr=8'h00 (NOP), if_id_pc=0, if_id_valid=0, halted=0. Reset dominates every other input.
- IDLE: outputs hold their reset values. When mem_ready=1, go to RUN with pc=0.
- RUN, per edge, in priority order:
  1. branch_taken=1: pc<=branch_target; if_id_instr<=8'h00; if_id_valid<=0 (flush).
  2. stall=1: pc and all IF/ID outputs hold.
  3. Otherwise: if_id_instr<=slot[pc]; if_id_pc<=pc; if_id_valid<=1; pc<=pc+1, modulo 8 (7 wraps to 0).
- Halt: in RUN, if an unstalled, unbranched fetch reads 8'hFF:
  - 8'hFF is latched into IF/ID with valid=1.
  - State goes to HALT; halted<=1; pc holds at the halt slot.
- HALT: each edge writes if_id_valid<=0 and if_id_instr<=8'h00. stall is ignored. branch_taken=1 (issued by an older in-flight branch) returns to RUN with pc<=branch_target and halted<=0.
- mem_ready=0 while in RUN or HALT: next edge returns to IDLE with reset values, which aborts the program for a reload.
- Simultaneous events: branch_taken beats stall; rst beats everything.

## Timing
- One-cycle fetch latency: slot[pc] presented before edge N appears on if_id_instr after edge N.
- pc is a registered output; slot selection is combinational from instrMem.
- First valid instruction: the edge after mem_ready is sampled high moves IDLE→RUN, and the following edge loads slot 0. if_id_valid first rises 2 edges after mem_ready is sampled.
- Branch: redirect takes effect on the same edge; the target instruction is valid one edge later, so there is exactly one bubble.
- Stall: zero-latency hold for as many cycles as stall is asserted.
- instrMem must not change while mem_ready=1; no change detection is performed.

## Configuration
- IF_HALT_EN
  - Defined: 8'hFF is the halt opcode and HALT behaviour is as above.
  - Undefined: 8'hFF is fetched as an ordinary instruction, the HALT state is never entered, and halted is tied to 0.

## Structure
- Shared package `core_pkg` holds:
  - INSTR_W, PC_W, DEPTH
  - NOP_INSTR = 8'h00, HALT_OPCODE = 8'hFF
  - fetch state enum {IDLE, RUN, HALT}
- Sub-module `instr_slot_mux`: combinational 64-to-8 selector that takes instrMem and pc and produces the slot instruction. It is reused by any debug readout.
- The remainder is one FSM, the PC register and the IF/ID register.

## Test plan
- Reset/idle: rst=1 for 2 cycles, mem_ready=0 → pc=0, if_id_valid=0, if_id_instr=00 throughout.
- Linear fetch with wrap: instrMem={88,89,8A,8C,90,A8,89,01} (slot 7..0, no FF), mem_ready=1 → IF/ID shows 01,89,A8,90,8C,8A,89,88, then 01 again; if_id_pc runs 0..7,0.
- Stall: stall=1 for 3 cycles after slot 2 is latched → if_id_instr holds slot 2 and pc holds 3; slot 3 appears on the edge after stall drops.
- Branch beats stall: branch_taken=1, stall=1, target=5 on the same edge → if_id_valid=0, pc=5; next edge presents slot 5.
- Halt (IF_HALT_EN): slot 4=FF → IF/ID shows FF valid, halted=1, pc=4, then valid=0 indefinitely. With the macro undefined, fetch continues to slot 5.
- Reload mid-run: mem_ready dropped at pc=6 → next edge IDLE, pc=0, valid=0. Raising mem_ready again restarts the sequence from slot 0.
